// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC register and IF/ID pipeline register with stall/flush counters
// Branch redirect outranks stall; counters saturate at 16'hFFFF.
module if_id_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic        Id_write,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] Id_instr,
  output logic [15:0] Id_pc,
  output logic        Id_valid,
  output logic [2:0]  Rs,
  output logic [2:0]  Rt,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  logic [15:0] pc;
  logic [15:0] pc_plus1;

  assign pc_plus1  = pc + 16'd1;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      Id_instr    <= 16'h0000;
      Id_pc       <= 16'h0000;
      Id_valid    <= 1'b0;
      stall_count <= 16'h0000;
      flush_count <= 16'h0000;
    end else begin
      if (branch_taken)
        pc <= branch_target;
      else if (PCwrite)
        pc <= pc_plus1;

      // A redirect squashes the fetched word into a NOP bubble.
      if (branch_taken) begin
        Id_instr <= 16'h0000;
        Id_pc    <= 16'h0000;
        Id_valid <= 1'b0;
      end else if (Id_write) begin
        Id_instr <= imem_data;
        Id_pc    <= pc_plus1;
        Id_valid <= 1'b1;
      end

      if (!PCwrite && !branch_taken && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (branch_taken && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end

  assign Rs = Id_valid ? Id_instr[11:9] : 3'd0;
  assign Rt = Id_valid ? Id_instr[8:6]  : 3'd0;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage
// Expected state is queued at drive time and compared one edge later.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCwrite, Id_write, branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] Id_instr, Id_pc;
  logic        Id_valid;
  logic [2:0]  Rs, Rt;
  logic [15:0] stall_count, flush_count;

  if_id_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .PCwrite(PCwrite), .Id_write(Id_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .Id_instr(Id_instr), .Id_pc(Id_pc), .Id_valid(Id_valid),
    .Rs(Rs), .Rt(Rt), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] + 8'h13};
  endfunction

  assign imem_data = mem_word(imem_addr);

  typedef struct {
    logic [15:0] pc, instr, idpc, stall, flush;
    logic        valid;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [15:0] m_pc, m_instr, m_idpc, m_stall, m_flush;
  logic        m_valid;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_idpc = 16'h0000;
    m_valid = 1'b0; m_stall = 16'h0000; m_flush = 16'h0000;
    q.delete();
  endtask

  // Entered and left on a falling edge.
  task automatic step(input logic pcw, input logic idw, input logic br, input logic [15:0] tgt);
    exp_t e;
    logic [2:0] ers, ert;
    PCwrite = pcw; Id_write = idw; branch_taken = br; branch_target = tgt;
    if (br) begin
      m_instr = 16'h0000; m_idpc = 16'h0000; m_valid = 1'b0;
    end else if (idw) begin
      m_instr = mem_word(m_pc); m_idpc = m_pc + 16'd1; m_valid = 1'b1;
    end
    if (!pcw && !br && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (br && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    if (br) m_pc = tgt;
    else if (pcw) m_pc = m_pc + 16'd1;
    e.pc = m_pc; e.instr = m_instr; e.idpc = m_idpc; e.valid = m_valid;
    e.stall = m_stall; e.flush = m_flush;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    ers = e.valid ? e.instr[11:9] : 3'd0;
    ert = e.valid ? e.instr[8:6]  : 3'd0;
    check("imem_addr",   imem_addr,   e.pc);
    check("Id_instr",    Id_instr,    e.instr);
    check("Id_pc",       Id_pc,       e.idpc);
    check("Id_valid",    {15'd0, Id_valid}, {15'd0, e.valid});
    check("Rs",          {13'd0, Rs}, {13'd0, ers});
    check("Rt",          {13'd0, Rt}, {13'd0, ert});
    check("stall_count", stall_count, e.stall);
    check("flush_count", flush_count, e.flush);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},    imem_addr,   16'h0000);
    check({tag, "_instr"}, Id_instr,    16'h0000);
    check({tag, "_idpc"},  Id_pc,       16'h0000);
    check({tag, "_valid"}, {15'd0, Id_valid}, 16'h0000);
    check({tag, "_rsrt"},  {10'd0, Rs, Rt}, 16'h0000);
    check({tag, "_stall"}, stall_count, 16'h0000);
    check({tag, "_flush"}, flush_count, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; PCwrite = 1'b0; Id_write = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // straight-line fetch of words 0..3
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
      check("line_instr", Id_instr, mem_word(16'(i)));
      check("line_idpc",  Id_pc,    16'(i + 1));
    end
    check("line_addr_end", imem_addr, 16'h0004);

    // load-use stall at PC=5
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    check("stall_pc",    imem_addr,   16'h0005);
    check("stall_held",  Id_instr,    mem_word(16'h0004));
    check("stall_count", stall_count, 16'h0002);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("resume_instr", Id_instr, mem_word(16'h0005));

    // branch at PC=8 alongside a stall request
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("pre_branch_pc", imem_addr, 16'h0008);
    step(1'b0, 1'b0, 1'b1, 16'h0040);
    check("br_pc",    imem_addr,   16'h0040);
    check("br_flush", flush_count, 16'h0001);
    check("br_stall", stall_count, 16'h0002);

    // repeat fetch, then drop a fetch
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("repeat_instr", Id_instr, mem_word(16'h0040));
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("skip_instr", Id_instr, mem_word(16'h0041));

    // PC wrap
    step(1'b1, 1'b1, 1'b1, 16'hFFFF);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("wrap_pc",   imem_addr, 16'h0000);
    check("wrap_idpc", Id_pc,     16'h0000);

    // async reset during a stall, between edges
    PCwrite = 1'b0; Id_write = 1'b0; branch_taken = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("post_rst_instr", Id_instr, mem_word(16'h0000));
    check("post_rst_idpc",  Id_pc,    16'h0001);

    // stall counter saturation
    for (int i = 0; i < 65537; i++)
      step(1'b0, 1'b0, 1'b0, 16'h0);
    check("sat_stall", stall_count, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("sat_stall_hold", stall_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 PCwrite  input  1  from hazard unit; 1 = PC may advance, 0 = hold PC.
REQ-006 Id_write  input  1  from hazard unit; 1 = IF/ID register may load, 0 = hold.
REQ-007 branch_taken  input  1  from EX; redirect PC and squash IF/ID this cycle.
REQ-008 branch_target  input  16  redirect address, word-addressed.
REQ-009 imem_addr  output  16  instruction memory address; equals current PC, combinational.
REQ-010 imem_data  input  16  instruction word returned combinationally for imem_addr.
REQ-011 Id_instr  output  16  registered instruction presented to decode.
REQ-012 Id_pc  output  16  registered PC+1 of the instruction in Id_instr.
REQ-013 Id_valid  output  1  1 = Id_instr is a real fetched instruction.
REQ-014 Rs  output  3  Id_instr[11:9], feeds the hazard unit Rs.
REQ-015 Rt  output  3  Id_instr[8:6], feeds the hazard unit Rt.
REQ-016 stall_count  output  16  count of stall cycles, saturating.
REQ-017 flush_count  output  16  count of branch redirects, saturating.

Function
REQ-018 The PC register SHALL update on each rising clk with priority: branch_taken (load branch_target) > PCwrite=1 (load PC+1) > hold.
REQ-019 PC+1 SHALL be 16-bit modulo: 16'hFFFF increments to 16'h0000 without error.
REQ-020 When branch_taken=1, IF/ID SHALL load Id_instr=16'h0000 (NOP), Id_valid=0, and Id_pc=0, regardless of Id_write.
REQ-021 When branch_taken=0 and Id_write=1, IF/ID SHALL load Id_instr=imem_data, Id_pc=PC+1 (modulo), and Id_valid=1.
REQ-022 When branch_taken=0 and Id_write=0, Id_instr, Id_pc, and Id_valid SHALL hold.
REQ-023 Fetch-to-decode latency SHALL be one cycle: the word at PC at edge N SHALL appear on Id_instr after edge N.
REQ-024 Rs and Rt SHALL be combinational slices of Id_instr; both are 0 whenever Id_valid=0.
REQ-025 The combination PCwrite=1, Id_write=0 SHALL advance the PC and hold IF/ID; the skipped instruction is dropped, and this is legal but never driven by the hazard unit.
REQ-026 The combination PCwrite=0, Id_write=1 SHALL reload IF/ID from the same PC, repeating the same instruction.
REQ-027 stall_count SHALL increment by 1 on each edge where PCwrite=0 and branch_taken=0, and SHALL stay at 16'hFFFF once reached.
REQ-028 flush_count SHALL increment by 1 on each edge where branch_taken=1, and SHALL stay at 16'hFFFF once reached.
REQ-029 Simultaneous branch_taken=1 and PCwrite=0 SHALL follow the branch, and stall_count SHALL NOT increment.
REQ-030 The block SHALL be pipelined without internal buffering beyond the PC and the IF/ID register; no FSM states beyond these registers are permitted.

Reset
REQ-031 While rst=1: PC=RESET_PC, Id_instr=0, Id_pc=0, Id_valid=0, stall_count=0, flush_count=0, asynchronously and independent of clk.
REQ-032 Reset asserted mid-stall or mid-branch SHALL abort the operation; the first edge after deassertion fetches from RESET_PC.
REQ-033 On the first edge after reset with PCwrite=1 and Id_write=1, the block SHALL set Id_instr=mem[RESET_PC], Id_pc=RESET_PC+1, and Id_valid=1.

Verification
REQ-034 Straight-line fetch: mem[0..3]=A,B,C,D, PCwrite=Id_write=1 for 4 edges -> Id_instr = A,B,C,D; Id_pc = 1,2,3,4; imem_addr ends at 4.
REQ-035 Load-use stall: at PC=5, drive PCwrite=Id_write=0 for 2 edges -> PC stays 5, Id_instr held, stall_count=2, then fetch resumes at 5.
REQ-036 Branch: at PC=8 drive branch_taken=1, branch_target=16'h0040 with PCwrite=0 -> PC=16'h0040, Id_valid=0, Id_instr=0, Rs=Rt=0, flush_count=1, stall_count unchanged.
REQ-037 Wrap: set PC=16'hFFFF via branch, then advance 1 edge -> PC=16'h0000, Id_pc=16'h0000.
REQ-038 Saturation: hold PCwrite=0 for 65537 edges -> stall_count=16'hFFFF and stays there.
REQ-039 Async reset: assert rst between clock edges during a stall -> all outputs reach their reset values immediately, before the next clk edge.
